// File: rtl/mem_row_cache_sync.sv
// mem_row_cache_sync: per-bank direct-mapped row-cache tags, evict/fill
// sequencing, round-robin sync request channel to the host row mover.
//
// Ports:
//   clk, reset_n               clock, async active-low reset
//   RowId[b], BankFSM[b]       per-bank row address and timing FSM state
//   cRowId[b], hit[b]          cache row index / residency of the open row
//   stall                      any bank sequencing an evict or fill
//   sync_req_*                 valid/ready request channel to the host
//   protocol_err               sticky: ACT seen while bank busy
module mem_row_cache_sync #(
  parameter int RANKS     = 1,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int CHWIDTH   = 5,
  parameter int ADDRWIDTH = 17,
  localparam int NBANKS   = RANKS * (2**BGWIDTH) * (2**BAWIDTH),
  localparam int BIDW     = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NBANKS-1:0][ADDRWIDTH-1:0]    RowId,
  input  logic [NBANKS-1:0][4:0]              BankFSM,
  output logic [NBANKS-1:0][CHWIDTH-1:0]      cRowId,
  output logic [NBANKS-1:0]                   hit,
  output logic                                stall,
  output logic                                sync_req_valid,
  input  logic                                sync_req_ready,
  output logic [BIDW-1:0]                     sync_req_bank,
  output logic                                sync_req_op,
  output logic [ADDRWIDTH-1:0]                sync_req_row,
  output logic [CHWIDTH-1:0]                  sync_req_crow,
  output logic                                protocol_err
);

  localparam int CHROWS = 2**CHWIDTH;
  localparam int TW     = ADDRWIDTH - CHWIDTH;
  // Zero-width tags are stored as a constant-zero bit so every valid
  // entry matches.
  localparam int TWS    = (TW > 0) ? TW : 1;

  localparam logic [4:0] ACT = 5'b00001;
  localparam logic [4:0] PR  = 5'b01010;
  localparam logic [4:0] WR0 = 5'b10010;
  localparam logic [4:0] WR1 = 5'b10011;

  typedef enum logic [1:0] {S_IDLE, S_EVICT, S_FILL} state_e;

  function automatic logic [TWS-1:0] tag_of(input logic [ADDRWIDTH-1:0] r);
    return TWS'(r >> CHWIDTH);
  endfunction

  state_e                             state_q [NBANKS];
  state_e                             state_d [NBANKS];
  logic [NBANKS-1:0]                  was_act_q, was_act_d;
  logic [NBANKS-1:0]                  hit_q, hit_d;
  logic [NBANKS-1:0][CHWIDTH-1:0]     crow_q, crow_d;
  logic [NBANKS-1:0][ADDRWIDTH-1:0]   row_q, row_d;
  logic [NBANKS-1:0][TWS-1:0]         otag_q, otag_d;
  logic [NBANKS-1:0][CHROWS-1:0]      valid_q, valid_d;
  logic [NBANKS-1:0][CHROWS-1:0]      dirty_q, dirty_d;
  logic [TWS-1:0]                     tag_q [NBANKS][CHROWS];
  logic [TWS-1:0]                     tag_d [NBANKS][CHROWS];

  logic                               lock_q, lock_d;
  logic [BIDW-1:0]                    sel_q, sel_d;
  logic [BIDW-1:0]                    rr_q, rr_d;
  logic                               rv_q, rv_d;
  logic                               op_q, op_d;
  logic [ADDRWIDTH-1:0]               prow_q, prow_d;
  logic [CHWIDTH-1:0]                 pcrow_q, pcrow_d;
  logic                               perr_q, perr_d;

  logic [NBANKS-1:0]                  pending;
  logic                               hs;
  logic                               found;
  logic [BIDW-1:0]                    pick;

  assign hs = rv_q && sync_req_ready;

  always_comb begin
    state_d   = state_q;
    was_act_d = was_act_q;
    hit_d     = hit_q;
    crow_d    = crow_q;
    row_d     = row_q;
    otag_d    = otag_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    tag_d     = tag_q;
    perr_d    = perr_q;
    pending   = '0;
    for (int b = 0; b < NBANKS; b++) begin
      logic [CHWIDTH-1:0] idx, cidx;
      logic [TWS-1:0]     ntag;
      logic               act_ev, is_pr, is_wr, hs_b, res;
      idx    = RowId[b][CHWIDTH-1:0];
      cidx   = row_q[b][CHWIDTH-1:0];
      ntag   = tag_of(RowId[b]);
      act_ev = (BankFSM[b] == ACT) && !was_act_q[b];
      is_pr  = BankFSM[b] == PR;
      is_wr  = (BankFSM[b] == WR0) || (BankFSM[b] == WR1);
      hs_b   = hs && (sel_q == BIDW'(b));
      res    = valid_q[b][idx] && (tag_q[b][idx] == ntag);
      was_act_d[b] = BankFSM[b] == ACT;
      pending[b]   = state_q[b] != S_IDLE;
      if (state_q[b] == S_IDLE) begin
        unique case (1'b1)
          act_ev: begin
            if (res) begin
              crow_d[b] = idx;
              hit_d[b]  = 1'b1;
            end else begin
              hit_d[b] = 1'b0;
              row_d[b] = RowId[b];
              if (valid_q[b][idx] && dirty_q[b][idx]) begin
                otag_d[b]  = tag_q[b][idx];
                state_d[b] = S_EVICT;
              end else begin
                state_d[b] = S_FILL;
              end
            end
          end
          is_pr:              hit_d[b] = 1'b0;
          is_wr && hit_q[b]:  dirty_d[b][crow_q[b]] = 1'b1;
          default: ;
        endcase
      end else begin
        if (act_ev) perr_d = 1'b1;
        if (is_pr)  hit_d[b] = 1'b0;
        if (hs_b && state_q[b] == S_EVICT) begin
          state_d[b] = S_FILL;
        end else if (hs_b) begin
          tag_d[b][cidx]   = tag_of(row_q[b]);
          valid_d[b][cidx] = 1'b1;
          dirty_d[b][cidx] = 1'b0;
          crow_d[b]        = cidx;
          hit_d[b]         = 1'b1;
          state_d[b]       = S_IDLE;
        end
      end
    end
  end

  // First pending bank at or after rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NBANKS; i++) begin
      int c;
      c = int'(rr_q) + i;
      if (c >= NBANKS) c = c - NBANKS;
      if (!found && pending[c]) begin
        found = 1'b1;
        pick  = BIDW'(c);
      end
    end
  end

  always_comb begin
    lock_d  = lock_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    rv_d    = rv_q;
    op_d    = op_q;
    prow_d  = prow_q;
    pcrow_d = pcrow_q;
    if (hs) begin
      rv_d   = 1'b0;
      lock_d = 1'b0;
      rr_d   = (sel_q == BIDW'(NBANKS - 1)) ? '0 : sel_q + 1'b1;
    end else if (!lock_q && found) begin
      lock_d  = 1'b1;
      rv_d    = 1'b1;
      sel_d   = pick;
      op_d    = state_q[pick] == S_EVICT;
      pcrow_d = row_q[pick][CHWIDTH-1:0];
      prow_d  = op_d ? ADDRWIDTH'({otag_q[pick], row_q[pick][CHWIDTH-1:0]})
                     : row_q[pick];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NBANKS; b++) begin
        state_q[b] <= S_IDLE;
        for (int e = 0; e < CHROWS; e++) tag_q[b][e] <= '0;
      end
      was_act_q <= '0;
      hit_q     <= '0;
      crow_q    <= '0;
      row_q     <= '0;
      otag_q    <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      lock_q    <= 1'b0;
      sel_q     <= '0;
      rr_q      <= '0;
      rv_q      <= 1'b0;
      op_q      <= 1'b0;
      prow_q    <= '0;
      pcrow_q   <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      was_act_q <= was_act_d;
      hit_q     <= hit_d;
      crow_q    <= crow_d;
      row_q     <= row_d;
      otag_q    <= otag_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      lock_q    <= lock_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      rv_q      <= rv_d;
      op_q      <= op_d;
      prow_q    <= prow_d;
      pcrow_q   <= pcrow_d;
      perr_q    <= perr_d;
    end
  end

  assign cRowId         = crow_q;
  assign hit            = hit_q;
  assign stall          = |pending;
  assign sync_req_valid = rv_q;
  assign sync_req_bank  = sel_q;
  assign sync_req_op    = op_q;
  assign sync_req_row   = prow_q;
  assign sync_req_crow  = pcrow_q;
  assign protocol_err   = perr_q;

endmodule

// File: tb/tb_mem_row_cache_sync.sv
// tb_mem_row_cache_sync: directed stimulus with a request scoreboard
// checked by an independent monitor on each handshake.
module tb_mem_row_cache_sync;

  localparam int NB = 16;
  localparam int AW = 17;
  localparam int CW = 5;
  localparam logic [4:0] ACT = 5'b00001;
  localparam logic [4:0] PR  = 5'b01010;
  localparam logic [4:0] WR0 = 5'b10010;
  localparam logic [4:0] WR1 = 5'b10011;
  localparam logic [4:0] NOP = 5'b00000;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [NB-1:0][AW-1:0]    RowId;
  logic [NB-1:0][4:0]       BankFSM;
  logic [NB-1:0][CW-1:0]    cRowId;
  logic [NB-1:0]            hit;
  logic                     stall;
  logic                     sync_req_valid;
  logic                     sync_req_ready;
  logic [3:0]               sync_req_bank;
  logic                     sync_req_op;
  logic [AW-1:0]            sync_req_row;
  logic [CW-1:0]            sync_req_crow;
  logic                     protocol_err;

  mem_row_cache_sync dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .RowId          (RowId),
    .BankFSM        (BankFSM),
    .cRowId         (cRowId),
    .hit            (hit),
    .stall          (stall),
    .sync_req_valid (sync_req_valid),
    .sync_req_ready (sync_req_ready),
    .sync_req_bank  (sync_req_bank),
    .sync_req_op    (sync_req_op),
    .sync_req_row   (sync_req_row),
    .sync_req_crow  (sync_req_crow),
    .protocol_err   (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    bank;
    logic          op;
    logic [AW-1:0] row;
    logic [CW-1:0] crow;
  } req_t;

  req_t sb_q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && sync_req_valid && sync_req_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_req got bank=%0d op=%0d row=%0h want none",
                 sync_req_bank, sync_req_op, sync_req_row);
      end else begin
        req_t e;
        e = sb_q.pop_front();
        chk("req_bank", 32'(sync_req_bank), 32'(e.bank));
        chk("req_op",   32'(sync_req_op),   32'(e.op));
        chk("req_row",  32'(sync_req_row),  32'(e.row));
        chk("req_crow", 32'(sync_req_crow), 32'(e.crow));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int b, input logic op, input logic [AW-1:0] r,
                      input int c);
    req_t e;
    e.bank = 4'(b);
    e.op   = op;
    e.row  = r;
    e.crow = CW'(c);
    sb_q.push_back(e);
  endtask

  task automatic act(input int b, input logic [AW-1:0] r);
    RowId[b]   = r;
    BankFSM[b] = ACT;
    tick();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || stall) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout got pending=%0d want 0", nm, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    RowId          = '0;
    BankFSM        = '0;
    sync_req_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(sync_req_valid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_hit",   32'(hit), 0);
    chk("rst_crow",  32'(|cRowId), 0);
    chk("rst_perr",  32'(protocol_err), 0);
    reset_n = 1'b1;
    tick();

    // Cold miss on bank 0: single fill.
    push(0, 1'b0, 17'h00025, 5);
    act(0, 17'h00025);
    chk("t1_stall", 32'(stall), 1);
    chk("t1_lat", 32'(sync_req_valid), 0);
    tick();
    chk("t1_valid", 32'(sync_req_valid), 1);
    drain("t1");
    chk("t1_hit",   32'(hit[0]), 1);
    chk("t1_crow",  32'(cRowId[0]), 5);
    chk("t1_stall_done", 32'(stall), 0);

    // Re-ACT of resident row: hit with no request.
    BankFSM[0] = PR;
    tick();
    chk("t2_pr_hit", 32'(hit[0]), 0);
    act(0, 17'h00025);
    chk("t2_hit", 32'(hit[0]), 1);
    chk("t2_stall", 32'(stall), 0);
    tick();
    chk("t2_novalid", 32'(sync_req_valid), 0);
    chk("t2_stall2", 32'(stall), 0);

    // Dirty conflict: evict old row then fill new one.
    BankFSM[0] = WR0;
    tick();
    BankFSM[0] = PR;
    tick();
    push(0, 1'b1, 17'h00025, 5);
    push(0, 1'b0, 17'h00045, 5);
    act(0, 17'h00045);
    drain("t3");
    chk("t3_hit",  32'(hit[0]), 1);
    chk("t3_crow", 32'(cRowId[0]), 5);

    // Advance rr_ptr to 2 with a fill on bank 1.
    push(1, 1'b0, 17'h00100, 0);
    act(1, 17'h00100);
    drain("t4a");

    // Simultaneous misses on 3, 1, 7 with rr_ptr=2.
    BankFSM[1] = PR;
    tick();
    push(3, 1'b0, 17'h00030, 16);
    push(7, 1'b0, 17'h0007f, 31);
    push(1, 1'b0, 17'h00200, 0);
    RowId[3]   = 17'h00030;
    RowId[1]   = 17'h00200;
    RowId[7]   = 17'h0007f;
    BankFSM[3] = ACT;
    BankFSM[1] = ACT;
    BankFSM[7] = ACT;
    tick();
    drain("t4b");
    chk("t4_stall", 32'(stall), 0);
    chk("t4_hits", 32'(hit & 16'h008a), 32'h008a);

    // rr_ptr back at 2: bank 2 must win over bank 1.
    BankFSM[1] = PR;
    tick();
    push(2, 1'b0, 17'h00022, 2);
    push(1, 1'b0, 17'h00400, 0);
    RowId[1]   = 17'h00400;
    RowId[2]   = 17'h00022;
    BankFSM[1] = ACT;
    BankFSM[2] = ACT;
    tick();
    drain("t4c");

    // Back-pressure: payload held, no reselection.
    sync_req_ready = 1'b0;
    act(4, 17'h10004);
    tick();
    chk("t5_perr0", 32'(protocol_err), 0);
    for (int i = 0; i < 10; i++) begin
      chk("t5_valid", 32'(sync_req_valid), 1);
      chk("t5_bank",  32'(sync_req_bank), 4);
      chk("t5_op",    32'(sync_req_op), 0);
      chk("t5_row",   32'(sync_req_row), 32'h10004);
      chk("t5_crow",  32'(sync_req_crow), 4);
      if (i == 2) begin
        RowId[9]   = 17'h00009;
        BankFSM[9] = ACT;
      end
      if (i == 4) BankFSM[4] = PR;
      if (i == 5) BankFSM[4] = ACT;
      tick();
    end
    chk("t5_perr1", 32'(protocol_err), 1);
    push(4, 1'b0, 17'h10004, 4);
    push(9, 1'b0, 17'h00009, 9);
    sync_req_ready = 1'b1;
    drain("t5");
    chk("t5_hit", 32'(hit & 16'h0210), 32'h0210);

    // Reset during an outstanding evict.
    sync_req_ready = 1'b0;
    BankFSM[0] = WR1;
    tick();
    BankFSM[0] = PR;
    tick();
    act(0, 17'h00025);
    tick();
    chk("t6_valid", 32'(sync_req_valid), 1);
    chk("t6_op",    32'(sync_req_op), 1);
    chk("t6_row",   32'(sync_req_row), 32'h00045);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(sync_req_valid), 0);
    chk("t6_rst_op",    32'(sync_req_op), 0);
    chk("t6_rst_row",   32'(sync_req_row), 0);
    chk("t6_rst_crow",  32'(sync_req_crow), 0);
    chk("t6_rst_bank",  32'(sync_req_bank), 0);
    chk("t6_rst_stall", 32'(stall), 0);
    chk("t6_rst_hit",   32'(hit), 0);
    chk("t6_rst_perr",  32'(protocol_err), 0);
    chk("t6_rst_crowid", 32'(|cRowId), 0);
    sb_q.delete();
    BankFSM = '0;
    tick();
    reset_n = 1'b1;
    sync_req_ready = 1'b1;
    tick();
    push(0, 1'b0, 17'h00025, 5);
    act(0, 17'h00025);
    chk("t6_miss", 32'(hit[0]), 0);
    drain("t6");
    chk("t6_hit", 32'(hit[0]), 1);

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
